// File: rtl/scale_pkg.sv
// scale_pkg: shared constants, FSM state type and reference-octave
// frequency table (octave 6, Q12.20) for the scale note snapper.
package scale_pkg;

  localparam int NUM_NOTES = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_LOOKUP,
    S_FAIL
  } state_t;

  function automatic logic [31:0] ref_freq(input logic [3:0] n);
    logic [31:0] f;
    case (n)
      4'd0:    f = 32'h41680943;
      4'd1:    f = 32'h454BB03A;
      4'd2:    f = 32'h496A8B8F;
      4'd3:    f = 32'h4DC82080;
      4'd4:    f = 32'h526829E4;
      4'd5:    f = 32'h574E9B58;
      4'd6:    f = 32'h5C7FA49F;
      4'd7:    f = 32'h61FFB539;
      4'd8:    f = 32'h67D3802A;
      4'd9:    f = 32'h6E000000;
      4'd10:   f = 32'h748A7B12;
      4'd11:   f = 32'h7B788802;
      default: f = 32'h0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/scale_snap_freq_if.sv
// scale_snap_freq_if: request/result bundle of the note snapper.
// master drives start/note/scale; slave returns busy/done/result.
interface scale_snap_freq_if #(
  parameter int FREQ_W = 32,
  parameter int OCT_W  = 3
);
  logic              start;
  logic [3:0]        note_name;
  logic [OCT_W-1:0]  note_octave;
  logic              greater;
  logic [11:0]       scale;
  logic              busy;
  logic              done;
  logic              no_note;
  logic [3:0]        snap_note;
  logic [OCT_W-1:0]  snap_octave;
  logic [FREQ_W-1:0] freq_desired;

  modport master (
    output start, note_name, note_octave,
    output greater, scale,
    input  busy, done, no_note,
    input  snap_note, snap_octave, freq_desired
  );

  modport slave (
    input  start, note_name, note_octave,
    input  greater, scale,
    output busy, done, no_note,
    output snap_note, snap_octave, freq_desired
  );
endinterface

// File: rtl/scale_freq_shift.sv
// scale_freq_shift: table lookup + octave shift (saturating left,
// truncating right; rounding right when SCALE_SNAP_ROUND_EN is defined).
// Ports: i_note, i_octave in; o_freq out (combinational).
module scale_freq_shift
  import scale_pkg::*;
#(
  parameter int FREQ_W  = 32,
  parameter int OCT_W   = 3,
  parameter int REF_OCT = 6
) (
  input  logic [3:0]        i_note,
  input  logic [OCT_W-1:0]  i_octave,
  output logic [FREQ_W-1:0] o_freq
);

  localparam int SH_W  = OCT_W + 1;
  localparam int MAXSH = 2 ** OCT_W;

  logic [31:0]             w_ref;
  logic [FREQ_W-1:0]       w_base;
  logic [SH_W-1:0]         w_oct;
  logic [SH_W-1:0]         w_ref_oct;
  logic [SH_W-1:0]         w_up_sh;
  logic [SH_W-1:0]         w_dn_sh;
  logic [FREQ_W+MAXSH-1:0] w_wide;
  logic                    w_sat;
  logic [FREQ_W-1:0]       w_rs;

  assign w_ref     = ref_freq(i_note);
  assign w_base    = FREQ_W'(w_ref >> (32 - FREQ_W));
  assign w_oct     = {1'b0, i_octave};
  assign w_ref_oct = SH_W'(REF_OCT);
  assign w_up_sh   = w_oct - w_ref_oct;
  assign w_dn_sh   = w_ref_oct - w_oct;

  // Anything landing above bit FREQ_W-1 was shifted out.
  assign w_wide = {{MAXSH{1'b0}}, w_base} << w_up_sh;
  assign w_sat  = |w_wide[FREQ_W+MAXSH-1:FREQ_W];

`ifdef SCALE_SNAP_ROUND_EN
  logic [FREQ_W:0] w_rnd_add;
  logic [FREQ_W:0] w_rnd;

  // Half-up: add the bit just below the kept LSB.
  assign w_rnd_add = {1'b0, w_base}
                   + ((FREQ_W+1)'(1) << (w_dn_sh - 1'b1));
  assign w_rnd     = w_rnd_add >> w_dn_sh;
  assign w_rs      = w_rnd[FREQ_W] ? '1 : w_rnd[FREQ_W-1:0];
`else
  assign w_rs = w_base >> w_dn_sh;
`endif

  always_comb begin
    o_freq = w_base;
    if (w_oct < w_ref_oct) begin
      o_freq = w_rs;
    end else if (w_oct > w_ref_oct) begin
      o_freq = w_sat ? '1 : w_wide[FREQ_W-1:0];
    end
  end

endmodule

// File: rtl/scale_snap_freq.sv
// scale_snap_freq: snaps a note to the nearest in-scale note by an
// outward search (one semitone step per cycle) and looks up its frequency.
// Ports: clk, reset (sync, active high), bus (scale_snap_freq_if.slave).
// Optional macro SCALE_SNAP_ROUND_EN: rounding right shifts.
module scale_snap_freq
  import scale_pkg::*;
#(
  parameter int FREQ_W    = 32,
  parameter int OCT_W     = 3,
  parameter int REF_OCT   = 6,
  parameter int MAX_STEPS = 6
) (
  input logic              clk,
  input logic              reset,
  scale_snap_freq_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_note;
  logic [OCT_W-1:0]  r_oct;
  logic              r_gr;
  logic [11:0]       r_scale;
  logic [2:0]        r_k;
  logic [3:0]        r_win_note;
  logic [OCT_W-1:0]  r_win_oct;
  logic              r_busy;
  logic              r_done;
  logic              r_no_note;
  logic [3:0]        r_snap_note;
  logic [OCT_W-1:0]  r_snap_oct;
  logic [FREQ_W-1:0] r_freq;

  logic              w_valid;
  logic [4:0]        w_up_sum;
  logic              w_up_wrap;
  logic [3:0]        w_up_note;
  logic [OCT_W:0]    w_up_oct;
  logic              w_up_hit;
  logic              w_dn_wrap;
  logic [3:0]        w_dn_note;
  logic [OCT_W-1:0]  w_dn_oct;
  logic              w_dn_hit;
  logic              w_hit;
  logic              w_pick_up;
  logic [FREQ_W-1:0] w_freq;

  assign w_valid = r_note < 4'(NUM_NOTES);

  // Up candidate: wrap B->C moves up an octave.
  assign w_up_sum  = {1'b0, r_note} + {2'b0, r_k};
  assign w_up_wrap = w_up_sum >= 5'(NUM_NOTES);
  assign w_up_note = w_up_wrap ? 4'(w_up_sum - 5'(NUM_NOTES))
                               : w_up_sum[3:0];
  assign w_up_oct  = {1'b0, r_oct} + (OCT_W+1)'(w_up_wrap);
  assign w_up_hit  = w_valid && !w_up_oct[OCT_W]
                   && r_scale[w_up_note];

  // Down candidate: wrap C->B moves down an octave.
  assign w_dn_wrap = r_note < {1'b0, r_k};
  assign w_dn_note = w_dn_wrap
                   ? 4'({1'b0, r_note} + 5'(NUM_NOTES) - {2'b0, r_k})
                   : r_note - {1'b0, r_k};
  assign w_dn_oct  = r_oct - OCT_W'(w_dn_wrap);
  assign w_dn_hit  = w_valid && !(w_dn_wrap && r_oct == '0)
                   && r_scale[w_dn_note];

  assign w_hit     = w_up_hit || w_dn_hit;
  assign w_pick_up = w_up_hit && (!w_dn_hit || r_gr);

  scale_freq_shift #(
    .FREQ_W  (FREQ_W),
    .OCT_W   (OCT_W),
    .REF_OCT (REF_OCT)
  ) u_shift (
    .i_note   (r_win_note),
    .i_octave (r_win_oct),
    .o_freq   (w_freq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (!w_valid) begin
          w_state_nxt = S_FAIL;
        end else if (w_hit) begin
          w_state_nxt = S_LOOKUP;
        end else if (r_k == 3'(MAX_STEPS)) begin
          w_state_nxt = S_FAIL;
        end
      end
      S_LOOKUP: w_state_nxt = S_IDLE;
      S_FAIL:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_note      <= '0;
      r_oct       <= '0;
      r_gr        <= 1'b0;
      r_scale     <= '0;
      r_k         <= '0;
      r_win_note  <= '0;
      r_win_oct   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_no_note   <= 1'b0;
      r_snap_note <= '0;
      r_snap_oct  <= '0;
      r_freq      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_note    <= bus.note_name;
            r_oct     <= bus.note_octave;
            r_gr      <= bus.greater;
            r_scale   <= bus.scale;
            r_k       <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_no_note <= 1'b0;
          end
        end
        S_SEARCH: begin
          r_k        <= r_k + 3'd1;
          r_win_note <= w_pick_up ? w_up_note : w_dn_note;
          r_win_oct  <= w_pick_up ? w_up_oct[OCT_W-1:0]
                                  : w_dn_oct;
        end
        S_LOOKUP: begin
          r_snap_note <= r_win_note;
          r_snap_oct  <= r_win_oct;
          r_freq      <= w_freq;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_no_note   <= 1'b0;
        end
        S_FAIL: begin
          r_snap_note <= '0;
          r_snap_oct  <= '0;
          r_freq      <= '0;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_no_note   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.no_note      = r_no_note;
  assign bus.snap_note    = r_snap_note;
  assign bus.snap_octave  = r_snap_oct;
  assign bus.freq_desired = r_freq;

endmodule

// File: doc/scale_snap_freq.md
Name: scale_snap_freq

Overview:
- Parametrised successor to the scale note-snapping lookup in the pitch-correction path.
- Takes a detected note (name + octave), a 12-bit scale mask and a direction hint; searches outward for the nearest in-scale note with a bounded, fixed-latency-per-step FSM.
- Outputs the snapped note, its octave, and its target frequency derived from a reference-octave table.
- Adds over the previous generation: a busy/done handshake, an empty-scale/out-of-range flag, octave-range checking, saturating shifts, and a configurable frequency width and octave width.

Parameters:
- FREQ_W, 32, output frequency width; legal 16..32; unsigned fixed point with 12 integer bits and FREQ_W-12 fraction bits.
- OCT_W, 3, octave field width; legal octaves 0..2^OCT_W-1.
- REF_OCT, 6, octave stored in the frequency table; must be ≤ 2^OCT_W-1.
- MAX_STEPS, 6, maximum search distance in semitones; legal 1..6.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  request pulse; accepted only while busy=0.
- note_name  in  4  detected note, 0=C .. 11=B; values 12..15 are invalid.
- note_octave  in  OCT_W  detected octave.
- greater  in  1  tie-break: 1 prefers the upward candidate, 0 prefers downward.
- scale  in  12  in-scale mask, bit0=C .. bit11=B; sampled at accept.
- busy  out  1  search in progress.
- done  out  1  result valid (level).
- no_note  out  1  no candidate found; qualifies done.
- snap_note  out  4  snapped note name.
- snap_octave  out  OCT_W  snapped octave.
- freq_desired  out  FREQ_W  snapped frequency.

Behaviour:
- Reset: state IDLE. busy, done, no_note, snap_note, snap_octave and freq_desired all 0. Reset mid-search aborts the search with no result.
- FSM states and transitions:
  - IDLE: start=1 latches note, octave, greater and scale; sets k=0, busy=1, done=0; goes to SEARCH.
  - SEARCH (one cycle per k): checks up = note+k and down = note−k with mod-12 wrap. Up wrapping B→C adds 1 to the octave; down wrapping C→B subtracts 1.
    - A candidate is a hit when its scale bit is 1 and its octave is in 0..2^OCT_W-1. An out-of-range candidate is never a hit.
    - Both hit: greater selects the winner. At k=0 both candidates are the same note.
    - Hit: go to LOOKUP.
    - No hit with k<MAX_STEPS: k+1, stay in SEARCH.
    - No hit with k=MAX_STEPS: go to FAIL.
    - note_name>11 at accept: go directly to FAIL.
  - LOOKUP: registers snap_note, snap_octave and freq_desired; done=1, busy=0, no_note=0; returns to IDLE.
  - FAIL: done=1, no_note=1, busy=0; freq_desired, snap_note and snap_octave = 0; returns to IDLE.
- Latency: done rises on cycle accept+k+2, where the accept cycle is cycle 0. The fail case on step exhaustion takes MAX_STEPS+2 cycles; an invalid note_name takes 2 cycles.
- done and results hold until the next accepted start, which clears done on the following edge.
- start while busy=1 is ignored, with no effect on the search in progress.
- Frequency: base = TABLE[snap_note] >> (32−FREQ_W).
  - snap_octave < REF_OCT: base >> (REF_OCT−snap_octave), truncating.
  - snap_octave > REF_OCT: base << (snap_octave−REF_OCT), saturating to all ones if any bit is shifted out.
  - Equal: base unchanged.

Optional Feature:
- Macro SCALE_SNAP_ROUND_EN.
- Defined: right shifts round half-up (add 1 at bit position shift−1 before shifting), then saturate if the result overflows.
- Undefined: right shifts truncate. Left-shift behaviour is identical either way.

Decomposition:
- Package scale_pkg holds:
  - the 12-entry 32-bit reference table for octave 6 in Q12.20 (C=0x41680943, C#=0x454BB03A, D=0x496A8B8F, D#=0x4DC82080, E=0x526829E4, F=0x574E9B58, F#=0x5C7FA49F, G=0x61FFB539, G#=0x67D3802A, A=0x6E000000, A#=0x748A7B12, B=0x7B788802);
  - NUM_NOTES=12;
  - the FSM state enum.
- One sub-module, scale_freq_shift: combinational table lookup plus saturating/rounding shift, registered by the parent in LOOKUP.

Test Plan:
- scale=0xAB5 (C major), note=1 (C#), oct=4, greater=1 → done at accept+3, snap=D/4, freq=0x125AA2E3, no_note=0.
- Same stimulus with greater=0 → snap=C/4, freq=0x105A0250. With SCALE_SNAP_ROUND_EN defined → 0x105A0251.
- scale=0x001, note=11 (B), oct=5, greater=1 → snap=C/6 via octave wrap at k=1, freq=0x41680943.
- scale=0x000, any valid note → done at accept+8, no_note=1, freq=0. Repeat with note_name=13 → done at accept+2, no_note=1.
- scale=0x001, note=10, oct=7 → up candidate C/8 rejected as out of range, down search exhausts at k=6 → no_note=1.
- scale=0x200, note=9 (A), oct=7 → freq=0xDC000000. Assert reset during SEARCH → next cycle all outputs 0, state IDLE. A start pulse while busy does not change the result.
